// File: rtl/io_input_scan.sv
// Debounce and change-detect front end for the memory-mapped switch/key ports.
// A round-robin scanner debounces one port per clock; the CPU reads stable values and sticky change flags.
module io_input_scan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 32
) (
  input  logic              io_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_port0,
  input  logic [DATA_W-1:0] in_port1,
  input  logic [DATA_W-1:0] in_port2,
  input  logic [31:0]       addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] io_read_data,
  output logic              irq
);

  localparam int         NPORTS  = 3;
  localparam logic [7:0] CNT_SAT = 8'(DEBOUNCE_CYCLES - 1);

  localparam logic [5:0] A_STABLE0 = 6'b100000;
  localparam logic [5:0] A_STABLE1 = 6'b100001;
  localparam logic [5:0] A_STABLE2 = 6'b100100;
  localparam logic [5:0] A_STATUS  = 6'b100110;
  localparam logic [5:0] A_MASK    = 6'b100111;

  logic [1:0]                     ptr;
  logic [NPORTS-1:0]              chg;
  logic [NPORTS-1:0]              mask;
  logic [NPORTS-1:0]              commit;
  logic [NPORTS-1:0][DATA_W-1:0]  raw_in;
  logic [NPORTS-1:0][DATA_W-1:0]  stable_q;
  logic [NPORTS-1:0][7:0]         cnt_q;

  logic [5:0] reg_sel;
  logic       status_rd;
  logic       mask_wr;
  logic       unused_bits;

  assign raw_in    = {in_port2, in_port1, in_port0};
  assign reg_sel   = addr[7:2];
  assign status_rd = rd_en && (reg_sel == A_STATUS);
  assign mask_wr   = wr_en && (reg_sel == A_MASK);

  assign unused_bits = ^{addr[31:8], addr[1:0], wdata[DATA_W-1:NPORTS]};

  // Per-port debounce: a port only moves when the scanner points at it.
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [DATA_W-1:0] cand;
    logic [DATA_W-1:0] stable;
    logic [7:0]        cnt;
    logic              scan;
    logic              same;
    logic              sat;

    assign scan = (ptr == 2'(p));
    assign same = (raw_in[p] == cand);
    assign sat  = (cnt == CNT_SAT);

    // The count saturates at CNT_SAT, so a held value keeps comparing against
    // stable without ever wrapping back into a fresh debounce window.
    assign commit[p]   = scan && same && sat && (cand != stable);
    assign stable_q[p] = stable;
    assign cnt_q[p]    = cnt;

    always_ff @(posedge io_clk) begin
      if (reset) begin
        cand   <= '0;
        stable <= '0;
        cnt    <= '0;
      end else if (scan) begin
        if (!same) begin
          cand <= raw_in[p];
          cnt  <= '0;
        end else if (!sat) begin
          cnt <= cnt + 8'd1;
        end else if (commit[p]) begin
          stable <= cand;
        end
      end
    end
  end

  // Scanner pointer, sticky change flags and interrupt mask.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      ptr  <= 2'd0;
      chg  <= '0;
      mask <= '0;
    end else begin
      ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
      // A commit in the same cycle as a clearing read keeps its own flag set.
      chg <= (status_rd ? '0 : chg) | commit;
      if (mask_wr) begin
        mask <= wdata[NPORTS-1:0];
      end
    end
  end

  always_comb begin
    io_read_data = '0;
    case (reg_sel)
      A_STABLE0: io_read_data = stable_q[0];
      A_STABLE1: io_read_data = stable_q[1];
      A_STABLE2: io_read_data = stable_q[2];
      A_STATUS:  io_read_data = {{(DATA_W-NPORTS){1'b0}}, chg};
      A_MASK:    io_read_data = {{(DATA_W-NPORTS){1'b0}}, mask};
      default:   io_read_data = '0;
    endcase
  end

  assign irq = |(chg & mask);

endmodule

// File: tb/tb_io_input_scan.sv
// Bench for io_input_scan: directed scenarios plus randomized traffic against a scan-history model.
module tb_io_input_scan;
  localparam int D    = 4;
  localparam int LOGN = 2048;

  logic        io_clk = 1'b0;
  logic        reset;
  logic [31:0] in_port0, in_port1, in_port2;
  logic [31:0] addr, wdata, io_read_data;
  logic        rd_en, wr_en, irq;

  always #5 io_clk = ~io_clk;

  io_input_scan #(.DEBOUNCE_CYCLES(D)) dut (
    .io_clk      (io_clk),
    .reset       (reset),
    .in_port0    (in_port0),
    .in_port1    (in_port1),
    .in_port2    (in_port2),
    .addr        (addr),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .wdata       (wdata),
    .io_read_data(io_read_data),
    .irq         (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [31:0] r [3];
  logic [31:0] obs_rd;
  logic        obs_irq;

  // Model: a value commits once the last D+1 scans of its port all saw it and it differs from stable.
  logic [31:0] log_v [3][LOGN];
  int          nscan [3];
  logic [31:0] m_stable [3];
  logic [2:0]  m_chg, m_mask;
  int          mptr;

  function automatic void m_reset();
    for (int p = 0; p < 3; p++) begin
      nscan[p]    = 1;
      log_v[p][0] = 32'h0;
      m_stable[p] = 32'h0;
    end
    m_chg  = 3'b000;
    m_mask = 3'b000;
    mptr   = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[7:2])
      6'b100000: return m_stable[0];
      6'b100001: return m_stable[1];
      6'b100100: return m_stable[2];
      6'b100110: return {29'b0, m_chg};
      6'b100111: return {29'b0, m_mask};
      default:   return 32'h0;
    endcase
  endfunction

  function automatic void m_step(input logic rst, input logic [31:0] a, input logic rd,
                                 input logic wr, input logic [31:0] wd);
    int         p;
    bit         held;
    logic [2:0] setb;
    if (rst) begin
      m_reset();
      return;
    end
    p    = mptr;
    setb = 3'b000;
    if (nscan[p] < LOGN) begin
      log_v[p][nscan[p]] = r[p];
      nscan[p]++;
    end
    if (nscan[p] >= D + 1) begin
      held = 1'b1;
      for (int k = 1; k <= D; k++)
        if (log_v[p][nscan[p]-1-k] != r[p]) held = 1'b0;
      if (held && r[p] != m_stable[p]) begin
        m_stable[p] = r[p];
        setb[p]     = 1'b1;
      end
    end
    if (rd && a[7:2] == 6'b100110) m_chg = 3'b000;
    m_chg = m_chg | setb;
    if (wr && a[7:2] == 6'b100111) m_mask = wd[2:0];
    mptr = (mptr + 1) % 3;
  endfunction

  task automatic tick(input logic rst_i, input logic [31:0] a, input logic rd,
                      input logic wr, input logic [31:0] wd);
    reset    = rst_i;
    in_port0 = r[0];
    in_port1 = r[1];
    in_port2 = r[2];
    addr     = a;
    rd_en    = rd;
    wr_en    = wr;
    wdata    = wd;
    #1;
    obs_rd  = io_read_data;
    obs_irq = irq;
    if (!rst_i) begin
      chk("rdata", io_read_data, m_read(a));
      chk("irq", 32'(irq), 32'(|(m_chg & m_mask)));
    end
    @(posedge io_clk);
    m_step(rst_i, a, rd, wr, wd);
    @(negedge io_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic align(input int p);
    for (int i = 0; i < 3 && mptr != p; i++) idle(1);
  endtask

  logic [31:0] atab [10];
  logic [31:0] vtab [4];
  logic [31:0] regs5 [5];

  initial begin
    atab  = '{32'h80, 32'h84, 32'h90, 32'h98, 32'h9C, 32'h88, 32'h00, 32'h94, 32'h180, 32'h19C};
    vtab  = '{32'h0, 32'h1, 32'h7, 32'hA5};
    regs5 = '{32'h80, 32'h84, 32'h90, 32'h98, 32'h9C};
    m_reset();
    r[0] = 32'hFFFF_FFFF;
    r[1] = 32'h0;
    r[2] = 32'h0;

    // reset state
    tick(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    r[0] = 32'h0;
    chk("ptr_after_reset", 32'(dut.ptr), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, regs5[i], 1'b0, 1'b0, 32'h0);
      chk("reset_read", obs_rd, 32'h0);
      chk("reset_irq", 32'(obs_irq), 32'h0);
    end

    // debounce latency
    tick(1'b0, 32'h9C, 1'b0, 1'b1, 32'h1);
    align(0);
    r[0] = 32'hA5;
    idle(10);
    tick(1'b0, 32'h80, 1'b0, 1'b0, 32'h0);
    chk("stable0_e9", obs_rd, 32'h0);
    idle(2);
    tick(1'b0, 32'h80, 1'b0, 1'b0, 32'h0);
    chk("stable0_e12", obs_rd, 32'hA5);
    chk("irq_e12", 32'(obs_irq), 32'h1);
    tick(1'b0, 32'h98, 1'b0, 1'b0, 32'h0);
    chk("chg_e12", obs_rd, 32'h1);

    // glitch rejection
    tick(1'b0, 32'h98, 1'b1, 1'b0, 32'h0);
    chk("clear_rd", obs_rd, 32'h1);
    align(1);
    r[1] = 32'h1;
    idle(6);
    r[1] = 32'h0;
    for (int i = 0; i < 15; i++) begin
      idle(1);
      chk("glitch_irq", 32'(obs_irq), 32'h0);
    end
    tick(1'b0, 32'h84, 1'b0, 1'b0, 32'h0);
    chk("glitch_stable1", obs_rd, 32'h0);
    tick(1'b0, 32'h98, 1'b0, 1'b0, 32'h0);
    chk("glitch_chg", obs_rd, 32'h0);

    // clearing read colliding with a commit
    r[0] = 32'h0;
    idle(15);
    tick(1'b0, 32'h98, 1'b0, 1'b0, 32'h0);
    chk("chg_pre_collide", obs_rd, 32'h1);
    align(2);
    r[2] = 32'h7;
    idle(12);
    tick(1'b0, 32'h98, 1'b1, 1'b0, 32'h0);
    chk("collide_rd", obs_rd, 32'h1);
    tick(1'b0, 32'h98, 1'b0, 1'b0, 32'h0);
    chk("collide_after", obs_rd, 32'h4);
    tick(1'b0, 32'h90, 1'b0, 1'b0, 32'h0);
    chk("stable2_7", obs_rd, 32'h7);

    // mask and irq
    tick(1'b0, 32'h98, 1'b1, 1'b0, 32'h0);
    r[0] = 32'h11;
    r[2] = 32'h22;
    idle(16);
    tick(1'b0, 32'h9C, 1'b0, 1'b1, 32'h4);
    tick(1'b0, 32'h98, 1'b0, 1'b0, 32'h0);
    chk("chg_both", obs_rd, 32'h5);
    chk("irq_mask4", 32'(obs_irq), 32'h1);
    tick(1'b0, 32'h9C, 1'b0, 1'b1, 32'h0);
    tick(1'b0, 32'h98, 1'b1, 1'b0, 32'h0);
    chk("chg_kept", obs_rd, 32'h5);
    chk("irq_mask0", 32'(obs_irq), 32'h0);
    tick(1'b0, 32'h98, 1'b0, 1'b0, 32'h0);
    chk("chg_cleared", obs_rd, 32'h0);

    // reset in the middle of a debounce
    align(2);
    r[2] = 32'h33;
    idle(6);
    tick(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("cnt2_reset", 32'(dut.cnt_q[2]), 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 32'h90, 1'b0, 1'b0, 32'h0);
      if (i == 0)  chk("stable2_reset", obs_rd, 32'h0);
      if (i == 14) chk("stable2_f11", obs_rd, 32'h0);
      if (i == 15) chk("stable2_f12", obs_rd, 32'h33);
    end

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] a;
      for (int p = 0; p < 3; p++)
        if ($urandom_range(0, 15) == 0)
          r[p] = ($urandom_range(0, 4) == 4) ? $urandom : vtab[$urandom_range(0, 3)];
      a = atab[$urandom_range(0, 9)];
      tick(($urandom_range(0, 399) == 0), a, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
